// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter
// Round-robin between ALU (A) and load (B); same-address pairs are ordered A then B.
module regfile_wb_arbiter #(
    parameter int data_width   = 32,
    parameter int select_width = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_valid,
    input  logic [select_width-1:0] a_addr,
    input  logic [data_width-1:0]   a_data,
    input  logic                    a_lui,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [select_width-1:0] b_addr,
    input  logic [data_width-1:0]   b_data,
    input  logic                    b_lui,
    output logic                    b_ready,
    input  logic                    wb_stall,
    output logic                    RegWrite,
    output logic [select_width-1:0] write_address,
    output logic [data_width-1:0]   write_data,
    output logic                    LUI,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ORDERED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   ptr;
    logic   ptr_next;
    logic   a_grant;
    logic   b_grant;
    logic   same_addr;
    logic   transfer;

    logic [select_width-1:0] sel_addr;
    logic [data_width-1:0]   sel_data;
    logic                    sel_lui;

    assign same_addr = (a_addr == b_addr);
    assign transfer  = a_grant | b_grant;
    assign sel_addr  = b_grant ? b_addr : a_addr;
    assign sel_data  = b_grant ? b_data : a_data;
    assign sel_lui   = b_grant ? b_lui  : a_lui;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (a_grant) begin
            ptr_next = 1'b1;
        end else if (b_grant) begin
            ptr_next = 1'b0;
        end
        case (state)
            ORDERED: begin
                if (wb_stall) begin
                    state_next = ORDERED;
                end else if (transfer) begin
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (a_grant && b_valid && same_addr) begin
                    state_next = ORDERED;
                end else if (transfer) begin
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Grants are gated by rst_n so both readies drop the instant reset asserts.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst_n && !wb_stall) begin
            if (state == ORDERED && b_valid) begin
                b_grant = 1'b1;
            end else if (a_valid && b_valid) begin
                if (same_addr || !ptr) begin
                    a_grant = 1'b1;
                end else begin
                    b_grant = 1'b1;
                end
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;
    assign busy    = (a_valid & ~a_grant) | (b_valid & ~b_grant);

    // Writes to r0 complete the handshake but leave the write port untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            LUI           <= 1'b0;
        end else begin
            RegWrite <= transfer && (sel_addr != '0);
            if (transfer && (sel_addr != '0)) begin
                write_address <= sel_addr;
                write_data    <= sel_data;
                LUI           <= sel_lui;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_lui, b_lui, wb_stall;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, RegWrite, LUI, busy;
    logic [4:0]  write_address;
    logic [31:0] write_data;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference model: who is owed a turn, and what the write port should show
    logic        m_ptr_b;
    logic        m_owed_b;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_lui;
    logic        exp_a, exp_b;
    logic        obs_a, obs_b, obs_busy;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_lui(a_lui), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_lui(b_lui), .b_ready(b_ready),
        .wb_stall(wb_stall), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .LUI(LUI), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr_b  = 1'b0;
        m_owed_b = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_lui    = 1'b0;
    endtask

    task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad, input logic al,
                          input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic bl,
                          input logic st);
        a_valid = av; a_addr = aa; a_data = ad; a_lui = al;
        b_valid = bv; b_addr = ba; b_data = bd; b_lui = bl;
        wb_stall = st;
    endtask

    // One clock: check handshake mid-cycle, advance the model at the edge, check write port after.
    task automatic step();
        @(negedge clk);
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (!wb_stall) begin
            if (m_owed_b && b_valid) exp_b = 1'b1;
            else if (a_valid && b_valid) begin
                if (a_addr == b_addr || !m_ptr_b) exp_a = 1'b1;
                else exp_b = 1'b1;
            end
            else if (a_valid) exp_a = 1'b1;
            else if (b_valid) exp_b = 1'b1;
        end
        obs_a = a_ready;
        obs_b = b_ready;
        obs_busy = busy;
        chk("a_ready", obs_a, exp_a);
        chk("b_ready", obs_b, exp_b);
        chk("busy", obs_busy, (a_valid & ~exp_a) | (b_valid & ~exp_b));
        @(posedge clk);
        m_we = 1'b0;
        if (exp_a && a_addr != 0) begin
            m_we = 1'b1; m_addr = a_addr; m_data = a_data; m_lui = a_lui;
        end
        if (exp_b && b_addr != 0) begin
            m_we = 1'b1; m_addr = b_addr; m_data = b_data; m_lui = b_lui;
        end
        if (exp_a) m_ptr_b = 1'b1;
        if (exp_b) m_ptr_b = 1'b0;
        if (!wb_stall) m_owed_b = exp_a && b_valid && (a_addr == b_addr);
        #1;
        chk("RegWrite", RegWrite, m_we);
        chk("write_address", write_address, m_addr);
        chk("write_data", write_data, m_data);
        chk("LUI", LUI, m_lui);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_data", write_data, 0);
        chk("rst_LUI", LUI, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // both valid, different addresses: alternate starting with A
        set_in(1, 4, 32'h44, 0, 1, 5, 32'h55, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("alt_grant_a", obs_a, (i % 2) == 0);
            chk("alt_busy", obs_busy, 1);
            chk("alt_we", RegWrite, 1);
            chk("alt_addr", write_address, ((i % 2) == 0) ? 4 : 5);
        end

        // single A request
        set_in(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0);
        step();
        chk("single_ready", obs_a, 1);
        chk("single_we", RegWrite, 1);
        chk("single_addr", write_address, 3);
        chk("single_data", write_data, 32'h1234);
        chk("single_lui", LUI, 0);

        // r0 write and LUI write
        set_in(1, 0, 32'hdead, 1, 0, 0, 0, 0, 0);
        step();
        chk("r0_ready", obs_a, 1);
        chk("r0_we", RegWrite, 0);
        chk("r0_hold_data", write_data, 32'h1234);
        set_in(1, 9, 32'hbeef, 1, 0, 0, 0, 0, 0);
        step();
        chk("lui_flag", LUI, 1);
        chk("lui_addr", write_address, 9);

        // same-address pair: A then B, load value lands last
        set_in(1, 7, 32'h11, 0, 1, 7, 32'h22, 0, 0);
        step();
        chk("ord_first_a", obs_a, 1);
        chk("ord_first_data", write_data, 32'h11);
        set_in(0, 7, 32'h11, 0, 1, 7, 32'h22, 0, 0);
        step();
        chk("ord_second_b", obs_b, 1);
        chk("ord_second_data", write_data, 32'h22);

        // stall while ORDERED, then B still owed
        set_in(1, 6, 32'h66, 0, 1, 6, 32'h77, 0, 0);
        step();
        set_in(1, 6, 32'h66, 0, 1, 6, 32'h77, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_a", obs_a, 0);
            chk("stall_b", obs_b, 0);
            chk("stall_busy", obs_busy, 1);
            chk("stall_we", RegWrite, 0);
        end
        set_in(1, 6, 32'h66, 0, 1, 6, 32'h77, 0, 0);
        step();
        chk("post_stall_b", obs_b, 1);
        chk("post_stall_data", write_data, 32'h77);

        // reset asserted mid-ORDERED discards the owed grant
        set_in(1, 8, 32'h88, 0, 1, 8, 32'h99, 0, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_we", RegWrite, 0);
        chk("async_addr", write_address, 0);
        chk("async_data", write_data, 0);
        chk("async_lui", LUI, 0);
        chk("async_a_ready", a_ready, 0);
        chk("async_b_ready", b_ready, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_in(1, 10, 32'haa, 0, 1, 11, 32'hbb, 0, 0);
        step();
        chk("post_rst_ptr_a", obs_a, 1);
        chk("post_rst_first_we", RegWrite, 1);
        set_in(1, 12, 32'hcc, 0, 1, 12, 32'hdd, 0, 0);
        step();
        chk("post_rst_idle_a", obs_a, 1);

        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001: Parameter data_width, default 32, width of the write-data path.
REQ-002: Parameter select_width, default 5, width of the register address.
REQ-003: Port clk, input, 1, single clock; all state SHALL change on its rising edge.
REQ-004: Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005: Port a_valid, input, 1, ALU writeback request.
REQ-006: Port a_addr, input, select_width, ALU destination register.
REQ-007: Port a_data, input, data_width, ALU result.
REQ-008: Port a_lui, input, 1, request is an upper-half (LUI) write.
REQ-009: Port a_ready, output, 1, ALU request accepted this cycle.
REQ-010: Ports b_valid, b_addr, b_data, b_lui, b_ready, with the same widths and meanings for the memory-load writeback requester.
REQ-011: Port wb_stall, input, 1, freezes grants while high.
REQ-012: Port RegWrite, output, 1, register-file write enable.
REQ-013: Port write_address, output, select_width, register-file write address.
REQ-014: Port write_data, output, data_width, register-file write data.
REQ-015: Port LUI, output, 1, register-file upper-half write select.
REQ-016: Port busy, output, 1, high when any valid requester is not granted this cycle.

Function
REQ-017: A transfer SHALL occur when x_valid and x_ready are both high in the same cycle.
- x_ready is combinational from the valids, the state and wb_stall.
- At most one of a_ready and b_ready SHALL be high in any cycle.
REQ-018: When wb_stall is high, a_ready and b_ready SHALL both be 0, and RegWrite SHALL be 0 in the following cycle.
REQ-019: Latency: a transfer in cycle T SHALL drive RegWrite=1 in cycle T+1 for exactly one cycle.
- write_address, write_data and LUI SHALL equal the accepted addr, data and lui.
- The outputs are registered.
REQ-020: A transfer with addr==0 SHALL complete the handshake, but RegWrite SHALL stay 0 in T+1 (register r0 is never written).
REQ-021: A single valid requester SHALL be granted in the same cycle, regardless of the round-robin pointer.
REQ-022: A 1-bit round-robin pointer SHALL select the winner when both requesters are valid and their addresses differ.
- After any grant, the pointer SHALL point to the non-granted requester.
REQ-023: The FSM SHALL have three states:
- IDLE: no write was issued in the previous cycle.
- WRITE: a write is being presented.
- ORDERED: the A grant of a same-address pair has been taken; the B grant is owed.
REQ-024: Transitions:
- IDLE/WRITE to WRITE on any transfer.
- IDLE/WRITE to IDLE when there is no transfer.
- IDLE/WRITE to ORDERED when both are valid with a_addr==b_addr, in which case A is granted irrespective of the pointer.
REQ-025: In ORDERED, B SHALL be granted first whenever b_valid is high and wb_stall is low, then the FSM goes to WRITE.
- If b_valid drops, the FSM SHALL return to normal arbitration.
- wb_stall SHALL hold the FSM in ORDERED.
REQ-026: With a same-address pair, the load value (B) SHALL be the last written, so the final register contents equal b_data.
REQ-027: busy SHALL equal (a_valid & ~a_ready) | (b_valid & ~b_ready).
REQ-028: When RegWrite is 0, write_address, write_data and LUI SHALL hold their last values.

Reset
REQ-029: While rst_n is 0, these SHALL be forced immediately and asynchronously:
- RegWrite=0, write_address=0, write_data=0, LUI=0.
- State=IDLE, pointer=A.
- a_ready=0, b_ready=0.
REQ-030: Reset asserted mid-operation SHALL discard any accepted-but-unissued write and any owed ORDERED grant.
REQ-031: The first grant after rst_n rises SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-032: Only A valid: addr=3, data=0x1234 in T -> a_ready=1 in T; in T+1, RegWrite=1, write_address=3, write_data=0x1234, LUI=0.
REQ-033: A and B both valid for 4 cycles with addr 4 and 5, pointer=A -> grants alternate A,B,A,B; RegWrite=1 on 4 consecutive cycles; busy=1 in each cycle.
REQ-034: A and B both valid with addr 7, a_data=0x11, b_data=0x22 -> A granted, then B; write_data sequence 0x11 then 0x22; ORDERED is visited once.
REQ-035: A valid with addr=0 -> a_ready=1; RegWrite stays 0 next cycle. With a_lui=1, addr=9 -> LUI=1 and write_address=9 next cycle.
REQ-036: wb_stall=1 for 3 cycles with both valid -> no ready, RegWrite=0, busy=1. rst_n pulsed low while in ORDERED -> all outputs 0 at once; after release, pointer=A and state=IDLE.
